ro_pair_counter: RTL and testbench
==================================

# ro_pair_counter

Measurement stage directly downstream of the ring-oscillator bank. It selects two oscillators by challenge and enables them. It counts the rising edges of each over a fixed window of `clk` cycles, then compares the two counts to produce one PUF response bit. It drives the `en` inputs of the oscillators and consumes their `out` signals.

## Interface

Parameters:
- `N_RO`, 4: number of ring oscillators attached.
- `SEL_W`, 2: width of each oscillator index (clog2 of `N_RO`).
- `CNT_W`, 16: edge-counter width.
- `WIN_CYCLES`, 1024: measurement window length in `clk` cycles; ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a measurement; sampled only in IDLE.
- `challenge`  in  2*SEL_W: `[SEL_W-1:0]` is index A, `[2*SEL_W-1:SEL_W]` is index B; captured on accepted `start`.
- `ro_out`  in  N_RO: oscillator outputs, bit i from oscillator i.
- `ro_en`  out  N_RO: oscillator enables, bit i to oscillator i.
- `busy`  out  1: high from the cycle after `start` is accepted through the RESULT cycle.
- `done`  out  1: one-cycle pulse in RESULT.
- `response`  out  1: 1 when count A > count B, else 0.
- `tie`  out  1: 1 when count A == count B.
- `count_a`, `count_b`  out  CNT_W: final edge counts, held until the next accepted `start`.

## Operation

- Input conditioning: each `ro_out` bit passes through a 2-flop synchronizer. A third register holds the previous synced value. A rising edge is synced==1 and prev==0. Conditioning runs continuously, independent of state.
- FSM states:
  - IDLE: `ro_en`=0, `busy`=0. When `start`=1, latch A/B indices, clear both counters, go to SETTLE.
  - SETTLE: 3 cycles. `ro_en` has bits A and B set; if A==B, only one bit. The synchronizer pipelines fill during this phase. No counting. Go to MEASURE.
  - MEASURE: exactly `WIN_CYCLES` cycles. On each cycle, counter A increments if an edge is detected on oscillator A; counter B does the same for oscillator B. Counters saturate at 2^CNT_W−1 and do not wrap. Go to RESULT.
  - RESULT: 1 cycle. `ro_en`=0. Register `response` = (cntA > cntB) and `tie` = (cntA == cntB). Copy the counts to `count_a`/`count_b`. Pulse `done`. Return to IDLE.
- A==B: the measurement runs normally. Both counters see the same edges, so the result is `tie`=1, `response`=0.
- Index ≥ `N_RO`: that counter never increments and its enable bit is not driven.
- `start` while not in IDLE is ignored. It is not queued.
- `challenge` is don't-care except in the accepting cycle.
- Comparison is unsigned, full CNT_W width. Saturated counts compare as equal.

## Timing

- Reset values: `ro_en`=0, `busy`=0, `done`=0, `response`=0, `tie`=0, `count_a`=0, `count_b`=0; FSM in IDLE; counters and synchronizers at 0.
- `start` is accepted at edge T0. `busy` and `ro_en` go high after T0. SETTLE covers cycles 1–3 and MEASURE covers cycles 4 to 3+WIN_CYCLES. RESULT is cycle 4+WIN_CYCLES.
- `done` is high for exactly the RESULT cycle. `response`, `tie` and `count_*` are valid in that cycle and stay stable until the next accepted `start`.
- A new `start` can be accepted in the cycle after RESULT. Back-to-back period is WIN_CYCLES+5 cycles.
- An edge on `ro_out` reaches the detector 3 cycles later. Edges that arrive during the final 3 MEASURE cycles are not counted. This is intended.
- `rst` mid-operation takes effect at the next edge. It aborts the measurement, drops `ro_en` and returns all outputs to reset values. No `done` is issued.

## Test plan

- Both selected `ro_out` held 0, challenge A=0,B=1 → `done` at cycle 1028; `count_a`=`count_b`=0, `tie`=1, `response`=0.
- `ro_out[2]` toggling every cycle (period 2), `ro_out[1]` period 4, both running before `start`, A=2, B=1 → `count_a`=512, `count_b`=256, `response`=1, `tie`=0; `ro_en`=4'b0110 during cycles 1–1027 only.
- CNT_W=4, WIN_CYCLES=64, A at period 2, B at period 4 → both counts saturate at 15, `tie`=1, `response`=0.
- `start` pulsed again at cycles 10 and 500 of a measurement → ignored; a single `done` occurs at cycle 1028 with counts unchanged from the no-pulse run.
- `rst` asserted at cycle 300 of a measurement → next cycle `ro_en`=0, `busy`=0, all outputs 0, no `done`; a fresh `start` then completes normally.
- A=B=3 with `ro_out[3]` at period 2 → `ro_en`=4'b1000, `count_a`=`count_b`=512, `tie`=1, `response`=0.

Source files
------------

// File: rtl/ro_pair_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ro_pair_counter
//  Brief    : Enables two challenge-selected ring oscillators, counts their
//             rising edges over a fixed window and compares the counts.
//  Revision : 1.0 - initial release
// ============================================================================
module ro_pair_counter #(
  parameter int N_RO       = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*SEL_W-1:0]   challenge,
  input  logic [N_RO-1:0]      ro_out,
  output logic [N_RO-1:0]      ro_en,
  output logic                 busy,
  output logic                 done,
  output logic                 response,
  output logic                 tie,
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b
);

  localparam int RO_PAD = 1 << SEL_W;
  localparam int WIN_W  = $clog2(WIN_CYCLES + 1);
  localparam int TMR_W  = (WIN_W < 2) ? 2 : WIN_W;
  localparam logic [TMR_W-1:0] C_SETTLE_LAST = TMR_W'(2);
  localparam logic [TMR_W-1:0] C_WIN_LAST    = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_RO-1:0]    r_sync1, r_sync2, r_prev;
  logic [N_RO-1:0]    w_edge;
  logic [RO_PAD-1:0]  w_edge_pad;
  logic [SEL_W-1:0]   r_idx_a, r_idx_b;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   r_cnt_a, r_cnt_b;
  logic [CNT_W-1:0]   w_cnt_a_nxt, w_cnt_b_nxt;
  logic               w_active;
  logic               w_busy;
  logic               w_done;

  // Free-running conditioning: two sync flops plus a history flop per oscillator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= ro_out;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // Indices beyond N_RO land on constant-zero pad bits and never count.
  for (genvar i = 0; i < RO_PAD; i++) begin : g_edge_pad
    if (i < N_RO) begin : g_live
      assign w_edge_pad[i] = w_edge[i];
    end else begin : g_dead
      assign w_edge_pad[i] = 1'b0;
    end
  end

  for (genvar i = 0; i < N_RO; i++) begin : g_ro_en
    assign ro_en[i] = w_active &&
                      ((r_idx_a == SEL_W'(i)) || (r_idx_b == SEL_W'(i)));
  end

  assign w_cnt_a_nxt = (w_edge_pad[r_idx_a] && (r_cnt_a != C_CNT_MAX))
                       ? r_cnt_a + CNT_W'(1) : r_cnt_a;
  assign w_cnt_b_nxt = (w_edge_pad[r_idx_b] && (r_cnt_b != C_CNT_MAX))
                       ? r_cnt_b + CNT_W'(1) : r_cnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_active = 1'b1;
        if (r_tmr == C_SETTLE_LAST) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        w_active = 1'b1;
        if (r_tmr == C_WIN_LAST) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  // Results are loaded on the last MEASURE edge so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx_a  <= '0;
      r_idx_b  <= '0;
      r_tmr    <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      count_a  <= '0;
      count_b  <= '0;
      response <= 1'b0;
      tie      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx_a <= challenge[SEL_W-1:0];
            r_idx_b <= challenge[2*SEL_W-1:SEL_W];
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_tmr   <= '0;
          end
        end
        S_SETTLE: begin
          r_tmr <= (r_tmr == C_SETTLE_LAST) ? '0 : r_tmr + TMR_W'(1);
        end
        S_MEASURE: begin
          r_tmr   <= r_tmr + TMR_W'(1);
          r_cnt_a <= w_cnt_a_nxt;
          r_cnt_b <= w_cnt_b_nxt;
          if (r_tmr == C_WIN_LAST) begin
            count_a  <= w_cnt_a_nxt;
            count_b  <= w_cnt_b_nxt;
            response <= (w_cnt_a_nxt > w_cnt_b_nxt);
            tie      <= (w_cnt_a_nxt == w_cnt_b_nxt);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ro_pair_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ro_pair_counter
//  Brief    : Directed self-checking bench for ro_pair_counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ro_pair_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  challenge = '0;
  logic [3:0]  ro_out;
  logic [3:0]  ro_en;
  logic        busy, done, response, tie;
  logic [15:0] count_a, count_b;

  logic        start_s = 1'b0;
  logic [3:0]  challenge_s = '0;
  logic [3:0]  ro_en_s;
  logic        busy_s, done_s, response_s, tie_s;
  logic [3:0]  count_a_s, count_b_s;

  logic [3:0]  osc_on = '0;
  logic [1:0]  ph = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Oscillator models: bits 2/3 period 2, bit 1 period 4, bit 0 idle.
  always @(negedge clk) ph <= ph + 2'd1;
  assign ro_out = {osc_on[3] & ph[0], osc_on[2] & ph[0], osc_on[1] & ph[1], 1'b0};

  ro_pair_counter #(.N_RO(4), .SEL_W(2), .CNT_W(16), .WIN_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_out(ro_out),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response), .tie(tie),
    .count_a(count_a), .count_b(count_b)
  );

  ro_pair_counter #(.N_RO(4), .SEL_W(2), .CNT_W(4), .WIN_CYCLES(64)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .challenge(challenge_s), .ro_out(ro_out),
    .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s), .tie(tie_s),
    .count_a(count_a_s), .count_b(count_b_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full measurement on the main DUT, sampled on falling edges; cycle 1 follows T0.
  task automatic run_meas(input logic [1:0] a, input logic [1:0] b, input logic [3:0] exp_en,
                          input int inj1, input int inj2,
                          output int done_cyc, output int done_cnt, output int en_err);
    @(negedge clk);
    challenge = {b, a};
    start     = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    done_cnt = 0;
    en_err   = 0;
    for (int c = 1; c <= 1040; c++) begin
      @(negedge clk);
      challenge = ~{b, a};
      start     = (c == inj1) || (c == inj2);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c <= 1027) begin
        if (ro_en !== exp_en || busy !== 1'b1) en_err++;
      end else if (c == 1028) begin
        if (ro_en !== 4'b0000 || busy !== 1'b1) en_err++;
      end else begin
        if (ro_en !== 4'b0000 || busy !== 1'b0) en_err++;
      end
    end
    start = 1'b0;
  endtask

  int dc, dn, ee;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_tie", tie, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_count_b", count_b, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Selected oscillators silent
    osc_on = 4'b0000;
    run_meas(2'd0, 2'd1, 4'b0011, -1, -1, dc, dn, ee);
    chk("idle_done_cycle", dc, 1028);
    chk("idle_done_count", dn, 1);
    chk("idle_en_busy", ee, 0);
    chk("idle_count_a", count_a, 0);
    chk("idle_count_b", count_b, 0);
    chk("idle_tie", tie, 1);
    chk("idle_response", response, 0);

    // A period 2, B period 4
    osc_on = 4'b0110;
    repeat (8) @(negedge clk);
    run_meas(2'd2, 2'd1, 4'b0110, -1, -1, dc, dn, ee);
    chk("ab_done_cycle", dc, 1028);
    chk("ab_en_busy", ee, 0);
    chk("ab_count_a", count_a, 512);
    chk("ab_count_b", count_b, 256);
    chk("ab_response", response, 1);
    chk("ab_tie", tie, 0);

    // Extra start pulses mid-measurement are ignored
    run_meas(2'd2, 2'd1, 4'b0110, 10, 500, dc, dn, ee);
    chk("inj_done_cycle", dc, 1028);
    chk("inj_done_count", dn, 1);
    chk("inj_en_busy", ee, 0);
    chk("inj_count_a", count_a, 512);
    chk("inj_count_b", count_b, 256);

    // Reset in the middle of a measurement
    @(negedge clk);
    challenge = 4'b0110;
    start     = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_response", response, 0);
    chk("abort_tie", tie, 0);
    chk("abort_count_a", count_a, 0);
    chk("abort_count_b", count_b, 0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 1040; c++) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_meas(2'd2, 2'd1, 4'b0110, -1, -1, dc, dn, ee);
    chk("post_abort_done_cycle", dc, 1028);
    chk("post_abort_count_a", count_a, 512);
    chk("post_abort_count_b", count_b, 256);

    // Narrow counters saturate and compare equal
    @(negedge clk);
    challenge_s = 4'b0110;
    start_s     = 1'b1;
    @(posedge clk);
    dc = -1;
    dn = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (done_s === 1'b1) begin
        dn++;
        if (dc < 0) dc = c;
      end
    end
    chk("sat_done_cycle", dc, 68);
    chk("sat_done_count", dn, 1);
    chk("sat_count_a", count_a_s, 15);
    chk("sat_count_b", count_b_s, 15);
    chk("sat_tie", tie_s, 1);
    chk("sat_response", response_s, 0);

    // Same oscillator selected twice
    osc_on = 4'b1000;
    repeat (8) @(negedge clk);
    run_meas(2'd3, 2'd3, 4'b1000, -1, -1, dc, dn, ee);
    chk("same_done_cycle", dc, 1028);
    chk("same_en_busy", ee, 0);
    chk("same_count_a", count_a, 512);
    chk("same_count_b", count_b, 512);
    chk("same_tie", tie, 1);
    chk("same_response", response, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
